// File: rtl/mips_cpu_muldiv_if.sv
// mips_cpu_muldiv_if: issue/result bundle between decode and the HI/LO
// multiply/divide unit. Signal names match the legacy port list.
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             clk_enable;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output clk_enable, start, op, a, b, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  clk_enable, start, op, a, b, mthi, mtlo,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Radix-2 shift-add multiplier, restoring divider, one bit per cycle.
// Optional: `define MIPS_MULDIV_EARLY_TERM_EN to let multiplies finish as
// soon as the remaining multiplier magnitude is zero.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,   // asynchronous, active low
  mips_cpu_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef MIPS_MULDIV_EARLY_TERM_EN
  // Early exit needs a position-independent product, so the multiplicand
  // shifts left into a double-width register instead of the accumulator
  // shifting right.
  localparam int AW = 2 * WIDTH;
`else
  localparam int AW = WIDTH;
`endif

  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               nsign_q, nsign_d;   // product / quotient negate
  logic               rsign_q, rsign_d;   // remainder negate
  logic               bzero_q, bzero_d;   // divisor was zero
  logic [WIDTH-1:0]   araw_q, araw_d;     // raw dividend for divide-by-zero
  logic [AW-1:0]      opa_q, opa_d;       // multiplicand / quotient
  logic [WIDTH-1:0]   opb_q, opb_d;       // multiplier / divisor
  logic [2*WIDTH:0]   acc_q, acc_d;       // product accumulator with carry
  logic [WIDTH:0]     rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic [WIDTH-1:0]   amag, bmag;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               last_step;
  logic               cancel;
`ifndef MIPS_MULDIV_EARLY_TERM_EN
  logic [WIDTH:0]     upper;
`endif

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != S_IDLE);

  // Next-state, datapath step and HI/LO write selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    nsign_d  = nsign_q;
    rsign_d  = rsign_q;
    bzero_d  = bzero_q;
    araw_d   = araw_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    signed_op = ~bus.op[0];
    amag      = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    bmag      = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Trial subtraction on the left-shifted remainder:quotient pair.
    diff = {rem_q, opa_q[WIDTH-1]} - {2'b00, opb_q};

    prod = acc_q[2*WIDTH-1:0];
    if (nsign_q) prod = -prod;
    quo_fix = nsign_q ? -opa_q[WIDTH-1:0] : opa_q[WIDTH-1:0];
    rem_fix = rsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    last_step = (cnt_q == CNT_ONE);
`ifdef MIPS_MULDIV_EARLY_TERM_EN
    last_step = last_step | (!is_div_q && (opb_q[WIDTH-1:1] == '0));
`else
    upper = acc_q[2*WIDTH:WIDTH] + (opb_q[0] ? {1'b0, opa_q} : '0);
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_CALC;
          cnt_d    = CNT_INIT;
          is_div_d = bus.op[1];
          nsign_d  = signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          rsign_d  = signed_op & bus.a[WIDTH-1];
          bzero_d  = (bus.b == '0);
          araw_d   = bus.a;
          opa_d    = AW'(amag);
          opb_d    = bmag;
          acc_d    = '0;
          rem_d    = '0;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (is_div_q) begin
          rem_d = diff[WIDTH+1] ? {rem_q[WIDTH-1:0], opa_q[WIDTH-1]} : diff[WIDTH:0];
          opa_d = AW'({opa_q[WIDTH-2:0], ~diff[WIDTH+1]});
        end else begin
`ifdef MIPS_MULDIV_EARLY_TERM_EN
          acc_d = acc_q + (opb_q[0] ? {1'b0, opa_q} : '0);
          opa_d = opa_q << 1;
`else
          acc_d = {1'b0, upper, acc_q[WIDTH-1:1]};
`endif
          opb_d = opb_q >> 1;
        end
        if (last_step) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (bzero_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A move-to-HI/LO while busy aborts the operation; results in FIX are
    // dropped so the untouched register keeps its pre-operation value.
    cancel = (bus.mthi | bus.mtlo) && (state_q != S_IDLE);
    if (cancel) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
    if (bus.mthi) hi_d = bus.a;
    if (bus.mtlo) lo_d = bus.a;
  end

  // State and datapath registers; everything holds while clk_enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      nsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      bzero_q  <= 1'b0;
      araw_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else if (bus.clk_enable) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      nsign_q  <= nsign_d;
      rsign_q  <= rsign_d;
      bzero_q  <= bzero_d;
      araw_q   <= araw_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Parametrised, iterative multiply/divide unit that owns the HI and LO registers for the MIPS core. It replaces the single-cycle `*`, `/` and `%` operators, which do not synthesise, with a radix-2 shift-add multiplier and a restoring divider. The decode stage issues MULT/MULTU/DIV/DIVU, MTHI and MTLO to this block and stalls on `busy`. MFHI/MFLO read `hi`/`lo` directly.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits; `WIDTH` must be ≥ 4.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-low reset (asserted at 0).
- `clk_enable`  in  1: when 0, all state holds.
- `start`  in  1: issue the operation selected by `op`.
- `op`  in  2: operation code. 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `a`  in  WIDTH: Rs operand (dividend or multiplicand).
- `b`  in  WIDTH: Rt operand (divisor or multiplier).
- `mthi`, `mtlo`  in  1: write `a` into HI or LO.
- `hi`, `lo`  out  WIDTH: architectural HI and LO.
- `busy`  out  1: operation in flight.
- `done`  out  1: one-cycle pulse, asserted in the same cycle HI and LO take the result.

## Operation
- State machine: IDLE → CALC → FIX → IDLE.
- IDLE, `start`=1 (sampled on an enabled edge):
  - Latch the operand magnitudes: absolute value for MULT/DIV, raw value for MULTU/DIVU.
  - Latch the result signs: product sign = a[W-1]^b[W-1]; quotient sign = a^b; remainder sign = a[W-1].
  - Load the step counter with WIDTH and go to CALC.
- CALC: one bit per cycle, decrementing the counter. Go to FIX when the counter reaches 1.
  - Multiply: if the multiplier LSB is set, add the multiplicand into the upper half of a 2·WIDTH accumulator, then shift the accumulator right.
  - Divide: shift the remainder:quotient pair left, trial-subtract the divisor, and keep the result when it is non-negative.
- FIX:
  - Apply the sign corrections (two's complement negation).
  - Multiply: HI ← product[2W-1:W], LO ← product[W-1:0].
  - Divide: LO ← quotient, HI ← remainder.
  - Pulse `done`, clear `busy`, return to IDLE.
- Divide by zero: HI ← `a`, LO ← all ones, for both DIV and DIVU.
- DIV of most-negative by −1: LO ← most-negative, HI ← 0.
- `start` while busy: ignored. The operation in flight is unaffected.
- `mthi`/`mtlo` while busy:
  - Cancels the operation: go to IDLE, clear `busy`, no `done` pulse.
  - The written register takes `a`; the other register keeps its pre-operation value.
- `mthi`/`mtlo` together with `start` in IDLE: the write takes effect, and the operation is also accepted. Its result overwrites HI/LO at FIX.
- `mthi` and `mtlo` together: both registers are written with `a`.
- Width rules:
  - Multiply accumulator: 2·WIDTH+1 bits, so the carry is kept.
  - Divider remainder: WIDTH+1 bits.
  - Counter: $clog2(WIDTH+1) bits.

## Timing
- Reset (asynchronous, takes effect immediately): `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE.
- Reset during CALC/FIX discards the operation. No `done` pulse is produced.
- `start` sampled at enabled edge N:
  - `busy`=1 after edge N.
  - `done`=1, `busy`=0 and the new `hi`/`lo` all appear after edge N+WIDTH+1.
  - Latency is WIDTH+1 enabled cycles; 33 for WIDTH=32.
- `done` is registered and lasts exactly one enabled cycle.
- `clk_enable`=0 freezes the state, counter, `busy` and `done`. Latency grows by the number of disabled cycles.
- `mthi`/`mtlo` update `hi`/`lo` on the next enabled edge, with single-cycle write semantics.
- A new `start` is accepted in the same cycle `done` is high, because the state is IDLE.

## Configuration
- `MIPS_MULDIV_EARLY_TERM_EN` defined:
  - Multiply leaves CALC as soon as the remaining multiplier magnitude is zero.
  - Latency becomes max(1, bit-length of |b|) + 1 enabled cycles.
  - A zero multiplier gives 2 cycles.
  - Divide latency is unchanged.
- Not defined: every operation takes exactly WIDTH+1 cycles.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` 33 cycles after `start` (macro off); `busy` high throughout.
- MULT a=0xFFFFFFFD (−3) b=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - With the macro on, b=5 gives `done` 4 cycles after `start`.
- DIV a=0xFFFFFFF9 (−7) b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU a=7 b=2 → `lo`=3, `hi`=1.
- DIV a=0x12345678 b=0 → `hi`=0x12345678, `lo`=0xFFFFFFFF.
  - DIV a=0x80000000 b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MULTU in flight; `mtlo` with a=0xCAFE0000 at cycle 10 → `busy` drops after that edge, no `done` pulse, `lo`=0xCAFE0000, `hi` unchanged.
  - A `start` at cycle 5 of an operation is ignored.
- `clk_enable`=0 for 5 cycles mid-DIVU → `done` 38 cycles after `start`.
  - `reset`=0 mid-operation → `busy`, `done`, `hi` and `lo` all go to 0 without waiting for a clock edge.
